noc_vc_credit_control: RTL

- Per-output-port credit and packet-state controller for the NoC router.
- Tracks downstream buffer credits and open-packet state for each virtual channel.
- Drives the per-VC ready vector that gates VC arbitration in the port controller.
- Sits between the port controller's output link and the downstream router's credit-return wires. Flags flow-control protocol violations.

---
 rtl/noc_vc_credit_control.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/noc_vc_credit_control.sv
// Per-output-port credit and open-packet tracker for each virtual channel.
// Produces the per-VC ready vector used by VC arbitration and sticky
// flow-control protocol error flags.
module noc_vc_credit_control #(
    parameter  int unsigned CHANNELS      = 2,
    parameter  int unsigned CREDITS       = 4,
    parameter  int unsigned SOP_THRESHOLD = 1,
    localparam int unsigned CREDIT_W      = $clog2(CREDITS + 1)
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst_n,
    input  logic                         flit_valid,
    input  logic [CHANNELS-1:0]          flit_vc,
    input  logic                         flit_sop,
    input  logic                         flit_eop,
    input  logic [CHANNELS-1:0]          credit_return,
    input  logic                         err_clear,
    output logic [CHANNELS-1:0]          vc_ready,
    output logic [CHANNELS-1:0]          vc_busy,
    output logic [CHANNELS*CREDIT_W-1:0] credit_count,
    output logic                         error,
    output logic [3:0]                   error_vec
);

    localparam int unsigned ERR_ZERO_SEND = 0;
    localparam int unsigned ERR_OVERFLOW  = 1;
    localparam int unsigned ERR_SOP_OPEN  = 2;
    localparam int unsigned ERR_BODY_IDLE = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } vc_state_t;

    logic [CREDIT_W-1:0] r_cnt [CHANNELS];
    vc_state_t           r_state [CHANNELS];
    logic [CHANNELS-1:0] r_busy;
    logic [3:0]          r_err;
    logic                r_error;

    logic [CREDIT_W-1:0] w_cnt_nxt [CHANNELS];
    vc_state_t           w_state_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_send;
    logic                w_onehot;
    logic [3:0]          w_err_set;
    logic [3:0]          w_err_nxt;

    // A flit only counts against a VC when flit_vc names exactly one VC
    always_comb begin
        w_onehot = (flit_vc != '0) && ((flit_vc & (flit_vc - CHANNELS'(1))) == '0);
        w_send   = (flit_valid && w_onehot) ? flit_vc : '0;
    end

    // Next credit count, next packet state and newly detected errors per VC
    always_comb begin
        w_err_set = '0;
        if (flit_valid && !w_onehot) begin
            w_err_set[ERR_BODY_IDLE] = 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i]   = r_cnt[i];
            w_state_nxt[i] = r_state[i];

            // Simultaneous send and return cancel out
            if (w_send[i] && !credit_return[i]) begin
                if (r_cnt[i] == '0) begin
                    w_err_set[ERR_ZERO_SEND] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - CREDIT_W'(1);
                end
            end else if (!w_send[i] && credit_return[i]) begin
                if (r_cnt[i] == CREDIT_W'(CREDITS)) begin
                    w_err_set[ERR_OVERFLOW] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CREDIT_W'(1);
                end
            end

            if (w_send[i]) begin
                if (r_state[i] == ST_IDLE) begin
                    if (flit_sop) begin
                        w_state_nxt[i] = flit_eop ? ST_IDLE : ST_OPEN;
                    end else begin
                        w_err_set[ERR_BODY_IDLE] = 1'b1;
                    end
                end else begin
                    // A stray head on an open VC is flagged and treated as body
                    if (flit_sop) begin
                        w_err_set[ERR_SOP_OPEN] = 1'b1;
                    end
                    if (flit_eop) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
            end
        end
    end

    // New errors win over a same-cycle clear
    always_comb begin
        w_err_nxt = (err_clear ? 4'b0000 : r_err) | w_err_set;
    end

    // State registers; synchronous reset dominates every other input
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]   <= CREDIT_W'(CREDITS);
                r_state[i] <= ST_IDLE;
            end
            r_busy  <= '0;
            r_err   <= '0;
            r_error <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]   <= w_cnt_nxt[i];
                r_state[i] <= w_state_nxt[i];
                r_busy[i]  <= (w_state_nxt[i] == ST_OPEN);
            end
            r_err   <= w_err_nxt;
            r_error <= |w_err_nxt;
        end
    end

    // Ready depends on registered state only: idle VCs need the start threshold
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state[i] == ST_IDLE) begin
                vc_ready[i] = (r_cnt[i] >= CREDIT_W'(SOP_THRESHOLD));
            end else begin
                vc_ready[i] = (r_cnt[i] >= CREDIT_W'(1));
            end
            credit_count[i*CREDIT_W +: CREDIT_W] = r_cnt[i];
        end
    end

    assign vc_busy   = r_busy;
    assign error_vec = r_err;
    assign error     = r_error;

endmodule
